// File: rtl/calc_sequencer.sv
// Sequencing FSM for the 8-bit calculator. It captures A, the operator and B,
// holds them steady for the ALU during a settle window, then latches the result.
module calc_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic [1:0]  op_sel,
  input  logic        enter_p,
  input  logic        op_p,
  input  logic        clr_p,
  input  logic [7:0]  alu_result,
  input  logic [2:0]  alu_rem,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [10:0] op_code,
  output logic [7:0]  result,
  output logic [2:0]  rem_q,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [10:0] sel_onehot;

  always_comb begin
    sel_onehot = '0;
    sel_onehot[op_sel] = 1'b1;
  end

  // Clear behaves exactly like reset, so it also wins over an EXEC completion.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_p) begin
      state   <= S_A;
      cnt     <= '0;
      a       <= '0;
      b       <= '0;
      op_code <= '0;
      result  <= '0;
      rem_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_A: begin
          if (enter_p) begin
            a     <= sw;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (op_p) begin
            op_code <= sel_onehot;
            state   <= S_B;
          end
        end
        S_B: begin
          if (op_p) begin
            op_code <= sel_onehot;
          end else if (enter_p) begin
            b     <= sw;
            cnt   <= '0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (op_code[3] && (b == 8'd0)) begin
              state <= S_ERR;
            end else begin
              result <= alu_result;
              rem_q  <= alu_rem;
              done   <= 1'b1;
              state  <= S_SHOW;
            end
          end
        end
        S_SHOW: begin
          if (op_p) begin
            a       <= result;
            b       <= '0;
            op_code <= sel_onehot;
            state   <= S_B;
          end else if (enter_p) begin
            a       <= sw;
            b       <= '0;
            op_code <= '0;
            state   <= S_OP;
          end
        end
        S_ERR: begin
        end
        default: state <= S_A;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  assign phase = state;
  assign busy  = (state == S_EXEC);
  assign err   = (state == S_ERR);

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the 8-bit calculator datapath. It captures operand A, the operator and operand B from the switches on button strobes, and drives `a`, `b` and the one-hot `op_code` into the ALU/display top. It waits a fixed settle time, then latches the ALU result and remainder and supports chained operations on the previous result. It also flags divide-by-zero and exposes a phase code that the display mux uses to choose what to show.

## Interface
- `SETTLE`, default 2: cycles spent in EXEC before the ALU output is latched. Legal range 1..15; the counter is 4 bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `sw`  in  8  operand value from the switches.
- `op_sel`  in  2  operator select: 00 add, 01 sub, 10 mul, 11 div.
- `enter_p`  in  1  one-cycle, debounced "enter" strobe.
- `op_p`  in  1  one-cycle "operator" strobe.
- `clr_p`  in  1  one-cycle "clear" strobe.
- `alu_result`  in  8  ALU `out_math`.
- `alu_rem`  in  3  ALU remainder.
- `a`  out  8  operand A to the ALU.
- `b`  out  8  operand B to the ALU.
- `op_code`  out  11  one-hot operator to the ALU. Bits 0..3 are add/sub/mul/div; bits 10:4 are always 0.
- `result`  out  8  latched result.
- `rem_q`  out  3  latched remainder.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `err`  out  1  high while in ERR.
- `busy`  out  1  high while in EXEC.
- `phase`  out  3  state code: A=0, OP=1, B=2, EXEC=3, SHOW=4, ERR=5.

## Operation
- **Reset.** `rst_n`=0 at an edge puts the block in A. All outputs are 0, `phase`=0.
- **Clear.** `clr_p` in any state, including mid-EXEC, has the same effect as reset.
- **Strobe priority** within one cycle: `clr_p` > `op_p` > `enter_p`. A strobe not listed for the current state is ignored.
- **A:** `enter_p` loads `a`<=`sw` and moves to OP.
- **OP:** `op_p` loads `op_code`<=onehot(`op_sel`) and moves to B. `enter_p` is ignored.
- **B:** `enter_p` loads `b`<=`sw`, clears the counter and moves to EXEC. `op_p` reloads `op_code` and stays in B, so the operator can be corrected.
- **EXEC:**
  - The counter increments every cycle.
  - On the edge where the counter equals SETTLE-1:
    - If `op_code[3]` and `b`==0: go to ERR; `result` and `rem_q` are unchanged.
    - Otherwise: `result`<=`alu_result`, `rem_q`<=`alu_rem`, `done`=1 for one cycle, go to SHOW.
  - `enter_p` and `op_p` are ignored.
- **SHOW:**
  - `op_p` chains: `a`<=`result`, `b`<=0, `op_code`<=onehot(`op_sel`), go to B.
  - `enter_p` starts a new calculation: `a`<=`sw`, `op_code`<=0, `b`<=0, go to OP.
- **ERR:** only `clr_p` leaves this state. `a`, `b` and `op_code` are held so the display shows the error pattern.
- **Output stability.** `a`, `b` and `op_code` are registered and never change during EXEC, so the ALU inputs are stable for the full settle window.
- **Arithmetic.** This block does no arithmetic; width handling is the ALU's job. For sub with `b`>`a`, `result` takes whatever the ALU supplies; no flag is raised here.

## Timing
- Strobes are sampled on the rising edge. Register updates are visible the cycle after the sampling edge.
- **Latency.** `enter_p` sampled in B at edge k:
  - EXEC (`busy`=1) covers edges k+1..k+SETTLE.
  - `done`=1, `phase`=4 after edge k+SETTLE.
  - `done` returns to 0 after edge k+SETTLE+1.
- **Unused cycles.** A strobe sampled on the edge that leaves EXEC is ignored. Back-to-back strobes on consecutive cycles are each honoured, according to the state in force at each edge.
- **Reset/clear priority.** `rst_n` low or `clr_p` on the same edge as the EXEC completion wins: no `done`, no `err`.

## Test plan
- **Reset.** Reset, then `sw`=0x0C + enter, `op_sel`=00 + op, `sw`=0x05 + enter; drive `alu_result`=0x11. Required: `op_code`=11'h001, `done` exactly SETTLE cycles after the B enter, `result`=0x11, `phase`=4.
- **Divide by zero.** `a`=0x09, div, `b`=0x00. Required: ERR with `err`=1, no `done` pulse; enter and op are ignored; `clr_p` gives `phase`=0 and all outputs 0.
- **Chaining.** From SHOW with `result`=0x11, `op_sel`=10 + op. Required: `a`=0x11, `b`=0, `op_code`=11'h004, `phase`=2.
- **Simultaneous strobes.** In SHOW, `op_p` and `enter_p` in the same cycle. Required: the chain path is taken (`phase`=2). With `clr_p` also asserted: `phase`=0.
- **Clear mid-EXEC.** `clr_p` one cycle into EXEC with SETTLE=4. Required: `phase`=0 next cycle, no `done`, `result` reset to 0.
- **Operator correction and parameters.** In B, op with 01 then op with 11. Required: `op_code`=11'h008, still in B. Re-run the basic sequence with SETTLE=1 and SETTLE=15 and confirm the `done` latency matches.
